arbitro_rr_fifo: RTL and testbench

//  Round-robin arbiter between the input FIFO bank and the output FIFO bank.

---
 rtl/arbitro_rr_fifo_pkg.sv | 24 ++
 rtl/arbitro_rr_fifo_if.sv | 24 ++
 rtl/arbitro_rr_fifo_rr_priority.sv | 35 +++
 rtl/arbitro_rr_fifo.sv | 82 ++++++++
 tb/tb_arbitro_rr_fifo.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitro_rr_fifo_pkg.sv
// Shared definitions for the round-robin FIFO arbiter: word geometry,
// port vector types and small decode helpers.
package arbitro_rr_fifo_pkg;

  localparam int DATA_W   = 6;
  localparam int N_PORTS  = 4;
  localparam int PORT_W   = 2;
  localparam int DEST_LSB = 4;

  typedef logic [PORT_W-1:0]  port_idx_t;
  typedef logic [N_PORTS-1:0] port_vec_t;
  typedef logic [DATA_W-1:0]  word_t;

  // Destination output FIFO carried inside a word.
  function automatic port_idx_t dest_of(input word_t w);
    return w[DEST_LSB +: PORT_W];
  endfunction

  // Index to one-hot port vector.
  function automatic port_vec_t onehot(input port_idx_t i);
    return port_vec_t'(1) << i;
  endfunction

endpackage

// File: rtl/arbitro_rr_fifo_if.sv
// FIFO-side bus of the arbiter: input bank pop/empty/data and output bank
// push/full/data. master = arbiter, slave = FIFO bank.
interface arbitro_rr_fifo_if;
  import arbitro_rr_fifo_pkg::*;

  port_vec_t                   in_empty;
  logic [N_PORTS*DATA_W-1:0]   in_data;
  port_vec_t                   pop;
  port_vec_t                   out_alm_full;
  port_vec_t                   out_full;
  port_vec_t                   push;
  word_t                       data_out;

  modport master (
    input  in_empty, in_data, out_alm_full, out_full,
    output pop, push, data_out
  );

  modport slave (
    output in_empty, in_data, out_alm_full, out_full,
    input  pop, push, data_out
  );

endinterface

// File: rtl/arbitro_rr_fifo_rr_priority.sv
// Combinational round-robin picker: first set request bit after the last
// granted index, scanning upward and wrapping 3 -> 0.
module rr_priority
  import arbitro_rr_fifo_pkg::*;
(
  input  port_vec_t req,
  input  port_idx_t last,
  output port_vec_t gnt,
  output port_idx_t idx
);

  port_idx_t cand;
  logic      found;

  // Scan last+1 .. last+4 (mod 4) and keep the first requester found.
  always_comb begin
    // NOTE: every output of this block gets a default before the loop; a
    // path that leaves one unassigned would infer a latch.
    gnt   = '0;
    idx   = last;
    found = 1'b0;
    cand  = last;
    for (int i = 1; i <= N_PORTS; i++) begin
      // NOTE: blocking assignments here, so cand is usable on the next line
      // within the same evaluation.
      cand = last + port_idx_t'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        gnt   = onehot(cand);
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_fifo.sv
// Round-robin arbiter moving words from the input FIFO bank to the output
// FIFO bank. Stage 0 picks and registers a pop, stage 1 remembers which port
// was popped, stage 2 captures the word and pushes it to its destination.
module arbitro_rr_fifo
  import arbitro_rr_fifo_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  arbitro_rr_fifo_if.master  bus,
  output port_idx_t          grant,
  output logic               error,
  output logic               idle
);

  port_vec_t req;
  port_vec_t win_vec;
  port_idx_t win_idx;
  logic      valid1;
  port_idx_t idx_q;
  word_t     in_word;
  logic      valid2;

  // Any almost_full output blocks all pops: the threshold leaves room for the
  // two words that may already be in flight.
  assign req = ~bus.in_empty & {N_PORTS{enable}} & {N_PORTS{~|bus.out_alm_full}};

  rr_priority u_prio (
    .req  (req),
    .last (grant),
    .gnt  (win_vec),
    .idx  (win_idx)
  );

  // Stage 0 pop register and stage 1 record of the popped port.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pop <= '0;
      grant   <= port_idx_t'(N_PORTS - 1);
      valid1  <= 1'b0;
      idx_q   <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every flop in the
      // pipeline samples the pre-edge values of the others.
      bus.pop <= win_vec;
      if (|req) grant <= win_idx;
      valid1  <= |bus.pop;
      idx_q   <= grant;
    end
  end

  // The FIFO presents the popped word one cycle after pop.
  assign in_word = bus.in_data[int'(idx_q)*DATA_W +: DATA_W];

  // Stage 2: capture the word and push it to its destination FIFO; the data
  // bus holds its last value while nothing is pushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.push     <= '0;
      bus.data_out <= '0;
    end else if (valid1) begin
      bus.push     <= onehot(dest_of(in_word));
      bus.data_out <= in_word;
    end else begin
      bus.push     <= '0;
    end
  end

  assign valid2 = |bus.push;

  // Sticky overflow flag: a push landed on a full output FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      error <= 1'b0;
    end else if (|(bus.push & bus.out_full)) begin
      error <= 1'b1;
    end
  end

  assign idle = ~|bus.pop & ~valid1 & ~valid2 & &bus.in_empty;

endmodule

// File: tb/tb_arbitro_rr_fifo.sv
// Directed bench for arbitro_rr_fifo. A small input-FIFO model reacts to
// pop (empty updates at the pop edge, data one cycle later); expected pop,
// push, data and grant per cycle are hand-computed tables.
module tb_arbitro_rr_fifo;
  import arbitro_rr_fifo_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      enable;
  port_idx_t grant;
  logic      error;
  logic      idle;

  arbitro_rr_fifo_if bus ();

  arbitro_rr_fifo dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus),
    .grant  (grant),
    .error  (error),
    .idle   (idle)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Input FIFO model.
  logic [5:0] fmem [4][8];
  int         fhd  [4];
  int         fcnt [4];
  logic [5:0] pend_w [4];
  bit         pend_v [4];

  // Expected-value tables, one row per cycle.
  int e_pop [32];
  int e_push [32];
  int e_data [32];
  int e_grant [32];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic load(input int p, input logic [5:0] w);
    fmem[p][(fhd[p] + fcnt[p]) % 8] = w;
    fcnt[p]++;
    bus.in_empty[p] = 1'b0;
  endtask

  // One clock; then the FIFO model reacts to what the DUT just registered.
  task automatic step();
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (pend_v[p]) begin
        bus.in_data[p*6 +: 6] = pend_w[p];
        pend_v[p] = 1'b0;
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (bus.pop[p]) begin
        check($sformatf("pop_nonempty_p%0d", p), (fcnt[p] > 0) ? 1 : 0, 1);
        if (fcnt[p] > 0) begin
          pend_w[p] = fmem[p][fhd[p]];
          pend_v[p] = 1'b1;
          fhd[p]    = (fhd[p] + 1) % 8;
          fcnt[p]--;
        end
      end
    end
    for (int p = 0; p < 4; p++) bus.in_empty[p] = (fcnt[p] == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic row(input int i, input int pop_v, input int push_v, input int data_v, input int grant_v);
    e_pop[i]   = pop_v;
    e_push[i]  = push_v;
    e_data[i]  = data_v;
    e_grant[i] = grant_v;
  endtask

  // e_data / e_grant of -1 mean "not checked on this cycle".
  task automatic run_steps(input string tname, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      step();
      check($sformatf("%s_pop%0d", tname, i), 32'(bus.pop), 32'(e_pop[i]));
      check($sformatf("%s_push%0d", tname, i), 32'(bus.push), 32'(e_push[i]));
      if (e_data[i] >= 0)
        check($sformatf("%s_data%0d", tname, i), 32'(bus.data_out), 32'(e_data[i]));
      if (e_grant[i] >= 0)
        check($sformatf("%s_grant%0d", tname, i), 32'(grant), 32'(e_grant[i]));
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b1;
    bus.in_empty = '1;
    bus.in_data = '0;
    bus.out_alm_full = '0;
    bus.out_full = '0;
    for (int p = 0; p < 4; p++) begin
      fhd[p] = 0; fcnt[p] = 0; pend_v[p] = 1'b0; pend_w[p] = '0;
    end
    step();
    do_reset();

    // Reset state.
    check("rst_pop", 32'(bus.pop), 0);
    check("rst_push", 32'(bus.push), 0);
    check("rst_data", 32'(bus.data_out), 0);
    check("rst_grant", 32'(grant), 3);
    check("rst_error", 32'(error), 0);
    check("rst_idle", 32'(idle), 1);

    // 1: single word 0x15 (dest 1) in FIFO 0.
    load(0, 6'h15);
    row(0, 1, 0, 0, 0);
    row(1, 0, 0, 0, 0);
    row(2, 0, 2, 'h15, 0);
    row(3, 0, 0, 'h15, 0);
    step();
    check("t1_pop_t", 32'(bus.pop), 1);
    check("t1_idle_t", 32'(idle), 0);
    run_steps("t1", 1, 3);
    check("t1_idle_t3", 32'(idle), 1);

    // 2: one word in each FIFO, priority starting at port 0.
    do_reset();
    load(0, 6'h30); load(1, 6'h05); load(2, 6'h1A); load(3, 6'h2C);
    row(0, 1, 0, 0, 0);
    row(1, 2, 0, 0, 1);
    row(2, 4, 8, 'h30, 2);
    row(3, 8, 1, 'h05, 3);
    row(4, 0, 2, 'h1A, 3);
    row(5, 0, 4, 'h2C, 3);
    row(6, 0, 0, 'h2C, 3);
    run_steps("t2", 0, 6);
    check("t2_idle", 32'(idle), 1);

    // 3: FIFOs 1 and 2 with three words each alternate.
    load(1, 6'h01); load(1, 6'h12); load(1, 6'h23);
    load(2, 6'h34); load(2, 6'h05); load(2, 6'h16);
    row(0, 2, 0, 'h2C, 1);
    row(1, 4, 0, 'h2C, 2);
    row(2, 2, 1, 'h01, 1);
    row(3, 4, 8, 'h34, 2);
    row(4, 2, 2, 'h12, 1);
    row(5, 4, 1, 'h05, 2);
    row(6, 0, 4, 'h23, 2);
    row(7, 0, 2, 'h16, 2);
    row(8, 0, 0, 'h16, 2);
    run_steps("t3", 0, 8);
    check("t3_idle", 32'(idle), 1);

    // 4: almost_full mid-stream; grant wraps 3 -> 0; single port back-to-back.
    load(3, 6'h20); load(3, 6'h21); load(3, 6'h22); load(3, 6'h23);
    load(0, 6'h00);
    row(0, 8, 0, 'h16, 3);
    row(1, 1, 0, 'h16, 0);
    row(2, 0, 4, 'h20, 0);
    row(3, 0, 1, 'h00, 0);
    row(4, 0, 0, 'h00, 0);
    row(5, 0, 0, 'h00, 0);
    row(6, 8, 0, 'h00, 3);
    row(7, 8, 0, 'h00, 3);
    row(8, 8, 4, 'h21, 3);
    row(9, 0, 4, 'h22, 3);
    row(10, 0, 4, 'h23, 3);
    row(11, 0, 0, 'h23, 3);
    run_steps("t4", 0, 1);
    bus.out_alm_full[2] = 1'b1;
    run_steps("t4", 2, 5);
    check("t4_idle_held", 32'(idle), 0);
    bus.out_alm_full[2] = 1'b0;
    run_steps("t4", 6, 11);
    check("t4_idle", 32'(idle), 1);

    // 5: push into a full output FIFO sets the sticky error.
    bus.out_full[0] = 1'b1;
    load(1, 6'h0A);
    row(0, 2, 0, 'h23, 1);
    row(1, 0, 0, 'h23, 1);
    row(2, 0, 1, 'h0A, 1);
    row(3, 0, 0, 'h0A, 1);
    run_steps("t5", 0, 2);
    check("t5_error_pre", 32'(error), 0);
    run_steps("t5", 3, 3);
    check("t5_error_set", 32'(error), 1);
    bus.out_full[0] = 1'b0;
    step(); step(); step();
    check("t5_error_sticky", 32'(error), 1);
    do_reset();
    check("t5_rst_error", 32'(error), 0);
    check("t5_rst_push", 32'(bus.push), 0);
    check("t5_rst_grant", 32'(grant), 3);

    // 6a: reset with two words in flight drops them.
    load(2, 6'h31); load(2, 6'h32);
    row(0, 4, 0, 0, 2);
    row(1, 4, 0, 0, 2);
    run_steps("t6a", 0, 1);
    do_reset();
    check("t6a_rst_pop", 32'(bus.pop), 0);
    check("t6a_rst_push", 32'(bus.push), 0);
    check("t6a_rst_grant", 32'(grant), 3);
    row(0, 0, 0, 0, 3);
    row(1, 0, 0, 0, 3);
    row(2, 0, 0, 0, 3);
    run_steps("t6a_post", 0, 2);
    check("t6a_idle", 32'(idle), 1);

    // 6b: enable drops with requests pending; the two in-flight words drain.
    load(0, 6'h01); load(1, 6'h11); load(2, 6'h21);
    row(0, 1, 0, 0, 0);
    row(1, 2, 0, 0, 1);
    row(2, 0, 1, 'h01, 1);
    row(3, 0, 2, 'h11, 1);
    row(4, 0, 0, 'h11, 1);
    row(5, 0, 0, 'h11, 1);
    row(6, 4, 0, 'h11, 2);
    row(7, 0, 0, 'h11, 2);
    row(8, 0, 4, 'h21, 2);
    row(9, 0, 0, 'h21, 2);
    run_steps("t6b", 0, 1);
    enable = 1'b0;
    run_steps("t6b", 2, 5);
    check("t6b_idle_off", 32'(idle), 0);
    enable = 1'b1;
    run_steps("t6b", 6, 9);
    check("t6b_idle", 32'(idle), 1);
    check("t6b_error", 32'(error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
